tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
- Parametrised successor to the fixed two-output clock divider.
- Produces NUM_CH cascaded tick-enable channels from the 100 MHz system clock. Each channel outputs a one-cycle tick pulse plus a half-rate toggle (square) output.
- Consumers (elevator FSM, door timer, display multiplexer) use ticks as clock enables, never as clocks.
- Adds over the old block: per-channel divisors, run enable, synchronous clear, async reset.

Parameters:
- NUM_CH, 3, number of cascaded channels (>=1).
- CNT_W, 17, width of each channel counter.
- DIV_LIST, {17'd2, 17'd1000, 17'd100000}, packed NUM_CH*CNT_W vector; slice k = divisor of channel k.
  - Channel 0 divides clk_100MHz.
  - Channel k>0 divides the tick of channel k-1.
  - Default gives 1 kHz, 1 Hz, 0.5 Hz ticks.

Ports:
- clk_100MHz  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  run enable for channel 0 (and therefore the whole cascade)
- sync_clr  in  1  synchronous clear of all channel state
- tick  out  NUM_CH  one-cycle enable pulse per channel
- sq  out  NUM_CH  toggle output per channel; period = 2 x tick period

Behaviour:
- Reset (reset_n low, asynchronous, no clock edge needed):
  - all counters, tick and sq go to 0 immediately and hold while reset_n is low.
  - Counting resumes on the first rising edge after release.
- Per channel k, on every rising edge:
  - Advance signal: adv[0] = en; adv[k] = tick[k-1] (registered value, k>0).
  - sync_clr=1: counter, tick[k] and sq[k] are set to 0. sync_clr has priority over en and adv.
  - Else if adv[k]:
    - if cnt[k]==DIV_k-1: cnt[k]<=0, tick[k]<=1, sq[k]<=~sq[k];
    - otherwise cnt[k]<=cnt[k]+1, tick[k]<=0.
  - Else: cnt[k] holds, tick[k]<=0, sq[k] holds.
- tick[k] is always exactly one clk_100MHz cycle wide. It is never high on two consecutive cycles unless DIV_k==1 and adv[k] is continuously high.
- Latency:
  - From reset release with en=1, tick[0] is first high after edge DIV_0.
  - tick[k] lags the tick[k-1] that completes it by exactly 1 cycle. The cascade skew is deliberate and constant.
- Period:
  - tick[0] period = DIV_0 cycles while en=1.
  - tick[k] period = product of DIV_0..DIV_k cycles.
- en low mid-count: the cascade freezes. Counts are retained, and resumption continues the same phase.
  - A tick[0] already registered still propagates to channel 1 on the next edge.
- DIV_k==1: channel k ticks on every advance. tick[k] is a 1-cycle-delayed copy of adv[k].
- Elaboration checks: DIV_k==0, or DIV_k > 2^CNT_W-1, is illegal. Flag it with a generate-time error (invalid instance in the generate block).
- No combinational path from any input to any output.

Decomposition:
- Shared header clkdiv_defs.vh holds:
  - CLK_HZ = 100_000_000;
  - default divisors DIV_1KHZ = 100000, DIV_1HZ = 1000;
  - the default DIV_LIST.
- One sub-module, tick_stage: a single counter channel with ports clk_100MHz, reset_n, sync_clr, adv, tick, sq and parameters CNT_W, DIV.
- tick_gen_multi is a generate loop chaining NUM_CH tick_stage instances.

Test Plan (bench uses NUM_CH=3, DIV_LIST={2,3,4}, i.e. DIV_0=4, DIV_1=3, DIV_2=2; edges counted from first rising edge after reset release, en=1):
- Basic cascade:
  - tick[0] high after edges 4, 8, 12, ...
  - tick[1] high after edges 13, 25, ...
  - tick[2] high after edges 26, 50, ...
  - Each tick is 1 cycle wide.
- Square outputs: sq[0] rises at edge 4 and falls at edge 8 (period 8). sq[1] rises at 13 and falls at 25. sq[2] rises at 26 and falls at 50.
- Enable pause:
  - Drop en for 10 cycles after edge 6 (en sampled low at edges 7-16, high again from edge 17). All outputs hold and no ticks occur during the pause.
  - tick[0] next rises after edge 18. The phase is preserved: 2 of 4 counts were done before the pause.
- sync_clr: pulse sync_clr for 1 cycle at edge 20. All ticks and sq are 0 after edge 20. tick[0] next rises after edge 24. tick[1] next rises after edge 33.
- Async reset mid-run: drive reset_n low between clock edges while sq[0]=1. sq and tick are 0 before the next edge. After release, behaviour is identical to the basic-cascade scenario.
- DIV_0=1 variant: tick[0] is high continuously from edge 1. sq[0] toggles every cycle. tick[1] period equals DIV_1.

Source files
------------

// File: rtl/tick_gen_multi_pkg.sv
// ----------------------------------------------------------------------------
// tick_gen_multi_pkg
//   Shared constants for the cascaded tick generator: system clock rate,
//   the default per-channel divisors and the default packed divisor list.
//   No ports; imported by tick_stage and tick_gen_multi.
// ----------------------------------------------------------------------------
package tick_gen_multi_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;

    // Default cascade: 100 MHz -> 1 kHz -> 1 Hz -> 0.5 Hz
    localparam int unsigned DIV_1KHZ    = 100_000;
    localparam int unsigned DIV_1HZ     = 1_000;
    localparam int unsigned DIV_HALF_HZ = 2;

    localparam int          DEF_NUM_CH  = 3;
    localparam int          DEF_CNT_W   = 17;

    // Slice k (LSB first) is the divisor of channel k.
    localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_DIV_LIST = {
        17'(DIV_HALF_HZ),
        17'(DIV_1HZ),
        17'(DIV_1KHZ)
    };

endpackage : tick_gen_multi_pkg

// File: rtl/tick_gen_multi_stage.sv
// ----------------------------------------------------------------------------
// tick_stage
//   One divider channel of the tick cascade. Counts advance pulses and emits
//   a one-cycle tick every DIV advances, plus a square output that toggles on
//   every tick.
//
//   Ports:
//     clk_100MHz  in   system clock
//     reset_n     in   asynchronous active-low reset
//     sync_clr    in   synchronous clear of counter, tick and sq
//     adv         in   advance enable (en for channel 0, previous tick else)
//     tick        out  registered one-cycle pulse every DIV advances
//     sq          out  registered toggle, period = 2 x tick period
// ----------------------------------------------------------------------------
module tick_stage
    import tick_gen_multi_pkg::*;
#(
    parameter int          CNT_W = 17,
    parameter int unsigned DIV   = 2
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic sync_clr,
    input  logic adv,
    output logic tick,
    output logic sq
);

    // A divisor of 0 can never terminate and one above the counter range can
    // never be reached; refuse to elaborate either.
    if ((DIV == 0) || (64'(DIV) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_div
        $error("tick_stage: DIV=%0d outside legal range 1..2^CNT_W-1 (CNT_W=%0d)",
               DIV, CNT_W);
    end

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (sync_clr) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (adv) begin
            if (cnt_q == TERM) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule : tick_stage

// File: rtl/tick_gen_multi.sv
// ----------------------------------------------------------------------------
// tick_gen_multi
//   NUM_CH cascaded tick-enable channels derived from the 100 MHz clock.
//   Channel 0 divides the clock (gated by en); channel k divides the
//   registered tick of channel k-1, so each stage adds one cycle of skew.
//   Ticks are clock enables for downstream logic, never clocks.
//
//   Ports:
//     clk_100MHz  in   system clock
//     reset_n     in   asynchronous active-low reset
//     en          in   run enable for channel 0 (freezes whole cascade)
//     sync_clr    in   synchronous clear of every channel
//     tick        out  [NUM_CH] one-cycle enable pulses
//     sq          out  [NUM_CH] square outputs, half the tick rate
// ----------------------------------------------------------------------------
module tick_gen_multi
    import tick_gen_multi_pkg::*;
#(
    parameter int                          NUM_CH   = DEF_NUM_CH,
    parameter int                          CNT_W    = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]     DIV_LIST = DEF_DIV_LIST
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              en,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("tick_gen_multi: NUM_CH=%0d must be at least 1", NUM_CH);
    end

    logic [NUM_CH-1:0] adv;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Each channel advances on the registered tick of its predecessor,
        // which keeps every input-to-output path behind a flop.
        if (k == 0) begin : g_first
            assign adv[k] = en;
        end else begin : g_next
            assign adv[k] = tick[k-1];
        end

        tick_stage #(
            .CNT_W (CNT_W),
            .DIV   (32'(DIV_LIST[k*CNT_W +: CNT_W]))
        ) u_stage (
            .clk_100MHz (clk_100MHz),
            .reset_n    (reset_n),
            .sync_clr   (sync_clr),
            .adv        (adv[k]),
            .tick       (tick[k]),
            .sq         (sq[k])
        );
    end

endmodule : tick_gen_multi

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 17;
    // Instance A: DIV_0=4, DIV_1=3, DIV_2=2. Instance B: DIV_0=1, DIV_1=3, DIV_2=2.
    localparam logic [NUM_CH*CNT_W-1:0] DIV_A = {17'd2, 17'd3, 17'd4};
    localparam logic [NUM_CH*CNT_W-1:0] DIV_B = {17'd2, 17'd3, 17'd1};

    logic              clk_100MHz = 1'b0;
    logic              reset_n    = 1'b1;
    logic              en         = 1'b0;
    logic              sync_clr   = 1'b0;
    logic [NUM_CH-1:0] tick_a, sq_a, tick_b, sq_b;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    tick_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_LIST(DIV_A)) u_dut_a (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .en         (en),
        .sync_clr   (sync_clr),
        .tick       (tick_a),
        .sq         (sq_a)
    );

    tick_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_LIST(DIV_B)) u_dut_b (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .en         (en),
        .sync_clr   (sync_clr),
        .tick       (tick_b),
        .sq         (sq_b)
    );

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk_100MHz);
        #1;
        edge_n++;
    endtask

    // Release reset just after an edge so the next edge is edge 1.
    task automatic release_reset();
        @(posedge clk_100MHz);
        #1;
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_100MHz);
        reset_n  = 1'b0;
        en       = 1'b1;
        sync_clr = 1'b0;
        step();
        release_reset();
    endtask

    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        en      = 1'b1;
        #1;
        // No clock edge has occurred yet: reset must act asynchronously.
        checks++;
        if ({tick_a, sq_a} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async_a got=%b required=%b", {tick_a, sq_a}, 6'b0);
        end
        checks++;
        if ({tick_b, sq_b} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async_b got=%b required=%b", {tick_b, sq_b}, 6'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({tick_a, sq_a, tick_b, sq_b} !== 12'b0) begin
                failures++;
                $display("FAIL reset_hold i=%0d got=%b required=%b", i,
                         {tick_a, sq_a, tick_b, sq_b}, 12'b0);
            end
        end
        release_reset();
    endtask

    // Expects reset released with en=1 and edge_n==0.
    task automatic test_basic_cascade(input string tag);
        logic [2:0] et, es;
        int e;
        for (int i = 0; i < 52; i++) begin
            step();
            e = edge_n;
            et[0] = (e % 4 == 0);
            et[1] = (e >= 13) && ((e - 13) % 12 == 0);
            et[2] = (e >= 26) && ((e - 26) % 24 == 0);
            es[0] = ((e / 4) % 2) == 1;
            es[1] = (e >= 13) && ((((e - 13) / 12) % 2) == 0);
            es[2] = (e >= 26) && ((((e - 26) / 24) % 2) == 0);
            checks++;
            if (tick_a !== et) begin
                failures++;
                $display("FAIL %s_tick edge=%0d got=%b required=%b", tag, e, tick_a, et);
            end
            checks++;
            if (sq_a !== es) begin
                failures++;
                $display("FAIL %s_sq edge=%0d got=%b required=%b", tag, e, sq_a, es);
            end
        end
    endtask

    task automatic test_enable_pause();
        logic [2:0] et, es;
        do_reset();
        for (int e = 1; e <= 19; e++) begin
            en = (e >= 7 && e <= 16) ? 1'b0 : 1'b1;
            step();
            et = {2'b00, (e == 4 || e == 18)};
            es = {2'b00, (e >= 4 && e < 18)};
            checks++;
            if (tick_a !== et) begin
                failures++;
                $display("FAIL pause_tick edge=%0d got=%b required=%b", e, tick_a, et);
            end
            checks++;
            if (sq_a !== es) begin
                failures++;
                $display("FAIL pause_sq edge=%0d got=%b required=%b", e, sq_a, es);
            end
        end
    endtask

    // Continues from edge 19 of test_enable_pause.
    task automatic test_sync_clr();
        logic [2:0] et, es;
        int e;
        en       = 1'b1;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        checks++;
        if ({tick_a, sq_a} !== 6'b0) begin
            failures++;
            $display("FAIL clr_a edge=%0d got=%b required=%b", edge_n, {tick_a, sq_a}, 6'b0);
        end
        checks++;
        if ({tick_b, sq_b} !== 6'b0) begin
            failures++;
            $display("FAIL clr_b edge=%0d got=%b required=%b", edge_n, {tick_b, sq_b}, 6'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            e = edge_n;
            et = {1'b0, (e == 33), (e % 4 == 0)};
            es = {1'b0, (e >= 33), ((((e - 20) / 4) % 2) == 1)};
            checks++;
            if (tick_a !== et) begin
                failures++;
                $display("FAIL clr_tick edge=%0d got=%b required=%b", e, tick_a, et);
            end
            checks++;
            if (sq_a !== es) begin
                failures++;
                $display("FAIL clr_sq edge=%0d got=%b required=%b", e, sq_a, es);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({tick_a[0], sq_a[0]} !== 2'b11) begin
            failures++;
            $display("FAIL areset_pre edge=%0d got=%b required=%b", edge_n,
                     {tick_a[0], sq_a[0]}, 2'b11);
        end
        #3;
        reset_n = 1'b0;
        #1;
        // Still well before the next rising edge.
        checks++;
        if ({tick_a, sq_a} !== 6'b0) begin
            failures++;
            $display("FAIL areset_mid got=%b required=%b", {tick_a, sq_a}, 6'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({tick_a, sq_a} !== 6'b0) begin
                failures++;
                $display("FAIL areset_hold i=%0d got=%b required=%b", i, {tick_a, sq_a}, 6'b0);
            end
        end
        release_reset();
        test_basic_cascade("after_areset");
    endtask

    task automatic test_div1();
        logic [2:0] et, es;
        int e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            e = edge_n;
            et[0] = 1'b1;
            et[1] = (e >= 4) && ((e - 4) % 3 == 0);
            et[2] = (e >= 8) && ((e - 8) % 6 == 0);
            es[0] = (e % 2) == 1;
            es[1] = ((((e - 1) / 3) % 2) == 1);
            es[2] = (e >= 8) && ((((e - 2) / 6) % 2) == 1);
            checks++;
            if (tick_b !== et) begin
                failures++;
                $display("FAIL div1_tick edge=%0d got=%b required=%b", e, tick_b, et);
            end
            checks++;
            if (sq_b !== es) begin
                failures++;
                $display("FAIL div1_sq edge=%0d got=%b required=%b", e, sq_b, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_cascade("basic");
        test_enable_pause();
        test_sync_clr();
        test_async_reset();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_tick_gen_multi
